// File: rtl/act_interp_scheduler_if.sv
// Bus bundle between the activation interpolator scheduler and its environment:
// requester handshake, LUT read port, interpolator operands/result and response strobe.
interface act_interp_scheduler_if #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int STEP_LOG2 = 4,
    parameter int ID_W      = $clog2(N_REQ)
);
    localparam int IDX_W = DATA_W - STEP_LOG2;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_z;
    logic [N_REQ-1:0]        req_ready;
    logic [IDX_W-1:0]        lut_addr;
    logic [DATA_W-1:0]       lut_data;
    logic [DATA_W-1:0]       itp_z;
    logic [DATA_W-1:0]       itp_base;
    logic [DATA_W-1:0]       itp_next;
    logic [DATA_W-1:0]       itp_int;
    logic [DATA_W-1:0]       itp_result;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    busy;

    modport slave (
        input  req_valid, req_z, lut_data, itp_result,
        output req_ready, lut_addr, itp_z, itp_base, itp_next, itp_int,
               rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_z, lut_data, itp_result,
        input  req_ready, lut_addr, itp_z, itp_base, itp_next, itp_int,
               rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/act_interp_scheduler.sv
// Round-robin scheduler sharing one combinational activation interpolator between N_REQ
// requesters: fetches the two bracketing LUT samples and returns a result tagged with the id.
module act_interp_scheduler #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int STEP_LOG2 = 4,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    act_interp_scheduler_if.slave bus
);
    localparam int IDX_W = DATA_W - STEP_LOG2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_B = 3'd1,
        FETCH_N = 3'd2,
        CAPT_N  = 3'd3,
        CALC    = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    id_r;
    logic [IDX_W-1:0]   lut_addr_r;
    logic [DATA_W-1:0]  itp_z_r;
    logic [DATA_W-1:0]  itp_int_r;
    logic [DATA_W-1:0]  base_r;
    logic [DATA_W-1:0]  next_r;
    logic               rsp_valid_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [DATA_W-1:0]  rsp_data_r;
    logic               busy_r;

    logic               grant_found_s;
    logic [ID_W-1:0]    grant_id_s;
    logic [N_REQ-1:0]   req_ready_s;
    logic               accept_s;
    logic [DATA_W-1:0]  sel_z_s;

    // Requester index k positions after p, wrapping at N_REQ.
    function automatic logic [ID_W-1:0] rr_step(input logic [ID_W-1:0] p, input int k);
        int s;
        s = (int'(p) + k) % N_REQ;
        return ID_W'(s);
    endfunction

    // Round-robin search starting just after the last winner.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            grant_id_s    = (!grant_found_s && bus.req_valid[rr_step(ptr_r, k)])
                            ? rr_step(ptr_r, k) : grant_id_s;
            grant_found_s = grant_found_s | bus.req_valid[rr_step(ptr_r, k)];
        end
    end

    // Grant strobe is combinational so a requester is accepted in the same IDLE cycle.
    always_comb begin
        req_ready_s = {N_REQ{1'b0}};
        if ((state_r == IDLE) && grant_found_s && !rst) begin
            req_ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_s;
        end else begin
            req_ready_s = {N_REQ{1'b0}};
        end
    end

    assign accept_s = |req_ready_s;
    assign sel_z_s  = bus.req_z[grant_id_s*DATA_W +: DATA_W];

    // Next-state logic for the fixed five-cycle service sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = accept_s ? FETCH_B : IDLE;
            FETCH_B: state_nxt_s = FETCH_N;
            FETCH_N: state_nxt_s = CAPT_N;
            CAPT_N:  state_nxt_s = CALC;
            CALC:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: latch the request, walk the LUT, capture the interpolated result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= ID_W'(N_REQ - 1);
            id_r        <= {ID_W{1'b0}};
            lut_addr_r  <= {IDX_W{1'b0}};
            itp_z_r     <= {DATA_W{1'b0}};
            itp_int_r   <= {DATA_W{1'b0}};
            base_r      <= {DATA_W{1'b0}};
            next_r      <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            busy_r      <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        ptr_r      <= grant_id_s;
                        id_r       <= grant_id_s;
                        itp_z_r    <= sel_z_s;
                        itp_int_r  <= {sel_z_s[DATA_W-1:STEP_LOG2], {STEP_LOG2{1'b0}}};
                        lut_addr_r <= sel_z_s[DATA_W-1:STEP_LOG2];
                    end else begin
                        ptr_r      <= ptr_r;
                    end
                end
                FETCH_B: begin
                    // Top segment has no upper neighbour: reuse the last sample.
                    lut_addr_r <= (lut_addr_r == {IDX_W{1'b1}})
                                  ? lut_addr_r
                                  : lut_addr_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
                FETCH_N: base_r <= bus.lut_data;
                CAPT_N:  next_r <= bus.lut_data;
                CALC: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= id_r;
                    rsp_data_r  <= bus.itp_result;
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.lut_addr  = lut_addr_r;
    assign bus.itp_z     = itp_z_r;
    assign bus.itp_base  = base_r;
    assign bus.itp_next  = next_r;
    assign bus.itp_int   = itp_int_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_act_interp_scheduler.sv
// Bench for act_interp_scheduler: linear LUT model, interpolator model, arbitration
// reference model with a response scoreboard, table vectors and directed corner sequences.
module tb_act_interp_scheduler;
    localparam int N_REQ = 4;
    localparam int DATA_W = 8;
    localparam int STEP_LOG2 = 4;
    localparam int ID_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    act_interp_scheduler_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .STEP_LOG2(STEP_LOG2), .ID_W(ID_W)) bus();

    act_interp_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .STEP_LOG2(STEP_LOG2), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] lut_f(input logic [3:0] k);
        return 8'(16 * int'(k));
    endfunction

    function automatic logic [7:0] itp_f(input logic [7:0] z, input logic [7:0] b,
                                         input logic [7:0] n, input logic [7:0] ip);
        int frac, diff, res;
        frac = int'(z) - int'(ip);
        diff = int'(n) - int'(b);
        res  = int'(b) + ((diff * frac) >>> 4);
        return 8'(res);
    endfunction

    function automatic logic [7:0] ref_data(input logic [7:0] z);
        logic [3:0] i, ni;
        i  = z[7:4];
        ni = (i == 4'hF) ? i : i + 4'd1;
        return itp_f(z, lut_f(i), lut_f(ni), {z[7:4], 4'h0});
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N_REQ; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment models: 1-cycle synchronous LUT ROM and combinational interpolator.
    always @(posedge clk) bus.lut_data <= lut_f(bus.lut_addr);
    assign bus.itp_result = itp_f(bus.itp_z, bus.itp_base, bus.itp_next, bus.itp_int);

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb_q[$];
    int         m_cnt;
    logic [1:0] m_ptr;
    int         wait_cnt[N_REQ];
    logic [3:0] acc_mask = 4'd0;
    logic [3:0] exp_ready;
    int         gid;
    bit         found;

    // Reference arbiter/timing model and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            m_cnt = 0;
            m_ptr = 2'd3;
            sb_q.delete();
            acc_mask = 4'd0;
            for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
            chk("ready_in_reset", bus.req_ready, 4'd0);
        end else begin
            exp_ready = 4'd0;
            found = 1'b0;
            gid = 0;
            if (m_cnt == 0) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    if (!found && bus.req_valid[(int'(m_ptr) + k) % N_REQ]) begin
                        found = 1'b1;
                        gid = (int'(m_ptr) + k) % N_REQ;
                    end
                end
            end
            if (found) exp_ready[gid] = 1'b1;
            chk("busy", bus.busy, (m_cnt != 0));
            chk("req_ready", bus.req_ready, exp_ready);
            acc_mask = bus.req_valid & bus.req_ready;
            if (found) begin
                chk("starvation", (wait_cnt[gid] < N_REQ), 1'b1);
                for (int i = 0; i < N_REQ; i++) begin
                    if (i == gid) wait_cnt[i] = 0;
                    else if (bus.req_valid[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                end
                sb_q.push_back('{2'(gid), ref_data(bus.req_z[gid*8 +: 8]), cyc + 5});
                m_ptr = 2'(gid);
                m_cnt = 4;
            end else begin
                if (m_cnt > 0) m_cnt--;
                for (int i = 0; i < N_REQ; i++) if (!bus.req_valid[i]) wait_cnt[i] = 0;
            end
            if (bus.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_cycle", cyc, e.due);
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                chk("rsp_missing", bus.rsp_valid, 1'b1);
                void'(sb_q.pop_front());
            end
        end
    end

    typedef struct {
        int         id;
        logic [7:0] z;
        logic [3:0] exp_idx;
        logic [3:0] exp_nidx;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic wait_grant(output int w, input int budget);
        w = -1;
        for (int t = 0; t < budget && w < 0; t++) begin
            @(negedge clk);
            w = oh_idx(bus.req_ready);
        end
        if (w < 0) chk("grant_timeout", bus.req_ready, 4'hF);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 20 && !idle; t++) begin
            @(negedge clk);
            idle = !bus.busy;
        end
        if (!idle) chk("idle_timeout", bus.busy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit seen2;
        int last;
        int order[5];
        logic [7:0] zz;

        vecs[0] = '{0, 8'd37,  4'd2,  4'd3,  8'd37};
        vecs[1] = '{0, 8'd250, 4'd15, 4'd15, 8'd240};
        vecs[2] = '{0, 8'd0,   4'd0,  4'd1,  8'd0};
        vecs[3] = '{1, 8'd255, 4'd15, 4'd15, 8'd240};
        vecs[4] = '{2, 8'd16,  4'd1,  4'd2,  8'd16};
        vecs[5] = '{3, 8'd239, 4'd14, 4'd15, 8'd239};
        vecs[6] = '{1, 8'd15,  4'd0,  4'd1,  8'd15};
        vecs[7] = '{2, 8'd241, 4'd15, 4'd15, 8'd240};
        order   = '{0, 1, 2, 3, 0};

        bus.req_valid = 4'd0;
        bus.req_z     = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {bus.lut_addr, bus.itp_z, bus.itp_base, bus.itp_next, bus.itp_int,
                              bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.busy, bus.req_ready}, 64'd0);

        // Table vectors: one request at a time, full pipeline inspected.
        for (int r = 0; r < 8; r++) begin
            @(posedge clk); #1;
            bus.req_z[vecs[r].id*8 +: 8] = vecs[r].z;
            bus.req_valid[vecs[r].id] = 1'b1;
            wait_grant(w, 10);
            chk("grant_vec", w, vecs[r].id);
            @(posedge clk); #1 bus.req_valid[vecs[r].id] = 1'b0;
            @(negedge clk); chk("lut_addr_base", bus.lut_addr, vecs[r].exp_idx);
            @(negedge clk); chk("lut_addr_next", bus.lut_addr, vecs[r].exp_nidx);
            repeat (2) @(negedge clk);
            chk("itp_z", bus.itp_z, vecs[r].z);
            chk("itp_int", bus.itp_int, {vecs[r].z[7:4], 4'h0});
            chk("itp_base", bus.itp_base, {vecs[r].exp_idx, 4'h0});
            chk("itp_next", bus.itp_next, {vecs[r].exp_nidx, 4'h0});
            @(negedge clk);
            chk("vec_rsp_valid", bus.rsp_valid, 1'b1);
            chk("vec_rsp_id", bus.rsp_id, vecs[r].id);
            chk("vec_rsp_data", bus.rsp_data, vecs[r].exp_data);
            @(negedge clk);
            chk("vec_rsp_pulse", bus.rsp_valid, 1'b0);
        end

        // All requesters held: strict rotation, back-to-back every 5 cycles.
        pulse_reset();
        @(posedge clk); #1;
        bus.req_z = {8'd200, 8'd130, 8'd77, 8'd5};
        bus.req_valid = 4'hF;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(w, 10);
            chk("rr_order", w, order[g]);
            if (g > 0) chk("rr_spacing", cyc - last, 5);
            last = cyc;
            @(posedge clk); #1;
            if (g == 4) bus.req_valid = 4'd0;
            else if (w >= 0) bus.req_z[w*8 +: 8] = 8'($urandom);
        end
        wait_idle();
        repeat (2) @(negedge clk);

        // Pointer at 1 with requesters 1 and 3 pending: 3 first; a dropped request is never granted.
        pulse_reset();
        @(posedge clk); #1; bus.req_z[15:8] = 8'd50; bus.req_valid[1] = 1'b1;
        wait_grant(w, 10);
        @(posedge clk); #1 bus.req_valid[1] = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        bus.req_z[15:8] = 8'd90; bus.req_z[31:24] = 8'd180;
        bus.req_valid[1] = 1'b1; bus.req_valid[3] = 1'b1;
        wait_grant(w, 10);
        chk("ptr1_first", w, 3);
        @(posedge clk); #1; bus.req_valid[3] = 1'b0; bus.req_z[23:16] = 8'd60; bus.req_valid[2] = 1'b1;
        seen2 = bus.req_ready[2];
        @(posedge clk); #1; bus.req_valid[2] = 1'b0;
        w = -1;
        for (int t = 0; t < 10 && w < 0; t++) begin
            @(negedge clk);
            seen2 = seen2 | bus.req_ready[2];
            w = oh_idx(bus.req_ready);
        end
        chk("ptr1_second", w, 1);
        chk("dropped_never_ready", seen2, 1'b0);
        @(posedge clk); #1 bus.req_valid[1] = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        // Reset in the middle of a request: no response, outputs cleared, pointer restored.
        @(posedge clk); #1; bus.req_z[7:0] = 8'd100; bus.req_valid[0] = 1'b1;
        wait_grant(w, 10);
        chk("rst_case_grant", w, 0);
        @(posedge clk); #1 bus.req_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {bus.lut_addr, bus.itp_z, bus.itp_base, bus.itp_next, bus.itp_int,
                               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.busy, bus.req_ready}, 64'd0);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", bus.rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        bus.req_z[7:0] = 8'd33; bus.req_z[15:8] = 8'd66;
        bus.req_valid[0] = 1'b1; bus.req_valid[1] = 1'b1;
        wait_grant(w, 10);
        chk("grant_after_rst", w, 0);
        @(posedge clk); #1 bus.req_valid = 4'd0;
        wait_idle();
        repeat (2) @(negedge clk);

        // Random traffic against the reference model.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc_mask[i]) begin
                    bus.req_valid[i] = 1'b0;
                end else if (bus.req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    zz = 8'($urandom);
                    bus.req_z[i*8 +: 8] = zz;
                    bus.req_valid[i] = 1'b1;
                end
            end
        end
        @(posedge clk); #1 bus.req_valid = 4'd0;
        repeat (8) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
